// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter feeding a single FIFO write port.
// One requester is locked for a whole packet; a stalled packet is
// force-released after TIMEOUT idle cycles from its owner.
module fifo_wr_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          timeout_err,
  output logic [15:0]                   pkt_count
);

  localparam int unsigned GW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state, state_nx;
  logic [GW-1:0] grant, grant_nx;
  logic [GW-1:0] rr_ptr, rr_nx;
  logic [7:0]    stall, stall_nx;
  logic [15:0]   pkts, pkts_nx;

  logic [GW-1:0] pick;
  logic          pick_ok;
  logic [GW:0]   scan_sum;
  logic [GW-1:0] grant_inc;
  logic          lock, abort, beat, grant_valid, grant_last;

  assign lock        = (state == LOCK);
  assign grant_valid = req_valid[grant];
  assign grant_last  = req_last[grant];
  assign abort       = lock && (stall == 8'(TIMEOUT));
  // The timeout cycle itself accepts nothing so the aborted owner sees no further ready.
  assign beat        = lock && !abort && grant_valid && !fifo_full;
  assign grant_inc   = (grant == GW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  assign busy        = lock;
  assign timeout_err = abort;
  assign fifo_w_en   = beat;
  assign grant_id    = grant;
  assign fifo_data   = req_data[grant*DATA_WIDTH +: DATA_WIDTH];
  assign pkt_count   = pkts;

  // Only the locked requester may see ready, and only when the FIFO has room.
  always_comb begin
    req_ready = '0;
    if (lock && !abort && !fifo_full) req_ready[grant] = 1'b1;
  end

  // Round-robin scan: first valid requester at or above rr_ptr, with wrap.
  always_comb begin
    pick     = '0;
    pick_ok  = 1'b0;
    scan_sum = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_sum = {1'b0, rr_ptr} + (GW+1)'(i);
      if (scan_sum >= (GW+1)'(NUM_REQ)) scan_sum = scan_sum - (GW+1)'(NUM_REQ);
      if (!pick_ok && req_valid[scan_sum[GW-1:0]]) begin
        pick    = scan_sum[GW-1:0];
        pick_ok = 1'b1;
      end
    end
  end

  // Next-state logic for the packet lock, pointer, stall timer and packet counter.
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    rr_nx    = rr_ptr;
    stall_nx = stall;
    pkts_nx  = pkts;
    case (state)
      IDLE: begin
        if (pick_ok) begin
          state_nx = LOCK;
          grant_nx = pick;
          stall_nx = '0;
        end
      end
      LOCK: begin
        if (abort) begin
          state_nx = IDLE;
          grant_nx = '0;
          rr_nx    = grant_inc;
          stall_nx = '0;
        end else if (beat && grant_last) begin
          state_nx = IDLE;
          grant_nx = '0;
          rr_nx    = grant_inc;
          stall_nx = '0;
          pkts_nx  = pkts + 16'd1;
        end else if (grant_valid) begin
          stall_nx = '0;
        end else begin
          stall_nx = stall + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      stall  <= '0;
      pkts   <= '0;
    end else begin
      state  <= state_nx;
      grant  <= grant_nx;
      rr_ptr <= rr_nx;
      stall  <= stall_nx;
      pkts   <= pkts_nx;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed vector table,
// hand-written corner sequences and a randomized model comparison.
module tb_fifo_wr_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned TO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_full = 1'b0;
  logic            fifo_w_en;
  logic [DW-1:0]   fifo_data;
  logic [1:0]      grant_id;
  logic            busy;
  logic            timeout_err;
  logic [15:0]     pkt_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_w_en(fifo_w_en), .fifo_data(fifo_data), .grant_id(grant_id),
    .busy(busy), .timeout_err(timeout_err), .pkt_count(pkt_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic eb, input logic [1:0] eg,
                           input logic [3:0] er, input logic ew, input logic [7:0] ed,
                           input logic et, input logic [15:0] ep);
    chk({tag, ".busy"},  32'(busy),        32'(eb));
    chk({tag, ".grant"}, 32'(grant_id),    32'(eg));
    chk({tag, ".ready"}, 32'(req_ready),   32'(er));
    chk({tag, ".w_en"},  32'(fifo_w_en),   32'(ew));
    chk({tag, ".data"},  32'(fifo_data),   32'(ed));
    chk({tag, ".terr"},  32'(timeout_err), 32'(et));
    chk({tag, ".pkts"},  32'(pkt_count),   32'(ep));
  endtask

  // Drive one cycle's inputs just after the falling edge, then settle.
  task automatic tick(input logic r, input logic [3:0] v, input logic [3:0] l,
                      input logic f, input logic [31:0] d);
    @(negedge clk);
    rst       = r;
    req_valid = v;
    req_last  = l;
    fifo_full = f;
    req_data  = d;
    #1;
  endtask

  typedef struct {
    logic        r;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [7:0]  d1;
    logic        f;
    logic        busy;
    logic [1:0]  g;
    logic [3:0]  rdy;
    logic        wen;
    logic [7:0]  data;
    logic        terr;
    logic [15:0] pkt;
  } vec_t;

  vec_t tbl[18];

  // Behavioural reference state.
  int m_lock, m_owner, m_ptr, m_idle, m_pkts;
  logic [3:0] active;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single packet from req1, then round-robin over four always-valid requesters.
    tbl[0]  = '{1'b1, 4'h0, 4'h0, 8'hA1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 8'hD0, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 4'h2, 4'h0, 8'hA1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 8'hD0, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, 4'h2, 4'h0, 8'hA1, 1'b0, 1'b1, 2'd1, 4'h2, 1'b1, 8'hA1, 1'b0, 16'd0};
    tbl[3]  = '{1'b0, 4'h2, 4'h0, 8'hA2, 1'b0, 1'b1, 2'd1, 4'h2, 1'b1, 8'hA2, 1'b0, 16'd0};
    tbl[4]  = '{1'b0, 4'h2, 4'h2, 8'hA3, 1'b0, 1'b1, 2'd1, 4'h2, 1'b1, 8'hA3, 1'b0, 16'd0};
    tbl[5]  = '{1'b0, 4'h0, 4'h0, 8'hA3, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 8'hD0, 1'b0, 16'd1};
    tbl[6]  = '{1'b1, 4'h0, 4'h0, 8'hD1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 8'hD0, 1'b0, 16'd0};
    tbl[7]  = '{1'b0, 4'hF, 4'hF, 8'hD1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 8'hD0, 1'b0, 16'd0};
    tbl[8]  = '{1'b0, 4'hF, 4'hF, 8'hD1, 1'b0, 1'b1, 2'd0, 4'h1, 1'b1, 8'hD0, 1'b0, 16'd0};
    tbl[9]  = '{1'b0, 4'hF, 4'hF, 8'hD1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 8'hD0, 1'b0, 16'd1};
    tbl[10] = '{1'b0, 4'hF, 4'hF, 8'hD1, 1'b0, 1'b1, 2'd1, 4'h2, 1'b1, 8'hD1, 1'b0, 16'd1};
    tbl[11] = '{1'b0, 4'hF, 4'hF, 8'hD1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 8'hD0, 1'b0, 16'd2};
    tbl[12] = '{1'b0, 4'hF, 4'hF, 8'hD1, 1'b0, 1'b1, 2'd2, 4'h4, 1'b1, 8'hD2, 1'b0, 16'd2};
    tbl[13] = '{1'b0, 4'hF, 4'hF, 8'hD1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 8'hD0, 1'b0, 16'd3};
    tbl[14] = '{1'b0, 4'hF, 4'hF, 8'hD1, 1'b0, 1'b1, 2'd3, 4'h8, 1'b1, 8'hD3, 1'b0, 16'd3};
    tbl[15] = '{1'b0, 4'hF, 4'hF, 8'hD1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 8'hD0, 1'b0, 16'd4};
    tbl[16] = '{1'b0, 4'hF, 4'hF, 8'hD1, 1'b0, 1'b1, 2'd0, 4'h1, 1'b1, 8'hD0, 1'b0, 16'd4};
    tbl[17] = '{1'b0, 4'h0, 4'h0, 8'hD1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 8'hD0, 1'b0, 16'd5};

    for (int i = 0; i < 18; i++) begin
      tick(tbl[i].r, tbl[i].v, tbl[i].l, tbl[i].f, {8'hD3, 8'hD2, tbl[i].d1, 8'hD0});
      check_all($sformatf("vec%0d", i), tbl[i].busy, tbl[i].g, tbl[i].rdy, tbl[i].wen,
                tbl[i].data, tbl[i].terr, tbl[i].pkt);
    end

    // Full stall in the middle of a 4-beat packet from req2.
    begin
      int k = 0;
      int stall_left = 5;
      logic f;
      tick(1'b1, 4'h0, 4'h0, 1'b0, 32'h0);
      tick(1'b0, 4'h4, 4'h0, 1'b0, 32'h0020_0000);
      chk("stall.idle_busy", 32'(busy), 32'd0);
      for (int c = 0; c < 30 && k < 4; c++) begin
        f = (k == 1 && stall_left > 0);
        if (f) stall_left--;
        tick(1'b0, 4'h4, (k == 3) ? 4'h4 : 4'h0, f, {8'h0, 8'(8'h20 + k), 16'h0});
        chk("stall.busy", 32'(busy), 32'd1);
        chk("stall.terr", 32'(timeout_err), 32'd0);
        chk("stall.grant", 32'(grant_id), 32'd2);
        if (f) begin
          chk("stall.w_en_full", 32'(fifo_w_en), 32'd0);
          chk("stall.ready_full", 32'(req_ready), 32'd0);
        end else begin
          chk("stall.w_en", 32'(fifo_w_en), 32'd1);
          chk("stall.data", 32'(fifo_data), 32'(8'h20 + k));
          k++;
        end
      end
      chk("stall.beats_written", 32'(k), 32'd4);
      chk("stall.windows_used", 32'(stall_left), 32'd0);
      tick(1'b0, 4'h0, 4'h0, 1'b0, 32'h0);
      chk("stall.busy_after", 32'(busy), 32'd0);
      chk("stall.pkts", 32'(pkt_count), 32'd1);
    end

    // Timeout: req0 sends one beat without last, then goes silent; req1 waits.
    tick(1'b1, 4'h0, 4'h0, 1'b0, 32'h0);
    tick(1'b0, 4'h3, 4'h0, 1'b0, 32'h0000_0055);
    chk("to.idle_busy", 32'(busy), 32'd0);
    tick(1'b0, 4'h3, 4'h0, 1'b0, 32'h0000_0055);
    chk("to.grant", 32'(grant_id), 32'd0);
    chk("to.beat_w_en", 32'(fifo_w_en), 32'd1);
    chk("to.beat_data", 32'(fifo_data), 32'h55);
    for (int c = 1; c <= 17; c++) begin
      tick(1'b0, 4'h2, 4'h0, 1'b0, 32'h0000_0055);
      chk($sformatf("to.terr_c%0d", c), 32'(timeout_err), 32'(c == 17));
      chk($sformatf("to.busy_c%0d", c), 32'(busy), 32'd1);
      chk($sformatf("to.w_en_c%0d", c), 32'(fifo_w_en), 32'd0);
    end
    tick(1'b0, 4'h2, 4'h0, 1'b0, 32'h0000_0055);
    check_all("to.released", 1'b0, 2'd0, 4'h0, 1'b0, 8'h55, 1'b0, 16'd0);
    tick(1'b0, 4'h2, 4'h0, 1'b0, 32'h0000_0055);
    check_all("to.next_grant", 1'b1, 2'd1, 4'h2, 1'b1, 8'h00, 1'b0, 16'd0);

    // Lock holds against req0, then a mid-packet reset restarts from index 0.
    tick(1'b1, 4'h0, 4'h0, 1'b0, 32'h4433_2211);
    tick(1'b0, 4'h2, 4'h2, 1'b0, 32'h4433_2211);
    tick(1'b0, 4'h2, 4'h2, 1'b0, 32'h4433_2211);
    chk("lr.pkt1_w_en", 32'(fifo_w_en), 32'd1);
    tick(1'b0, 4'h8, 4'h0, 1'b0, 32'h4433_2211);
    chk("lr.idle_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick(1'b0, 4'h9, 4'h0, 1'b0, 32'h4433_2211);
      check_all($sformatf("lr.lock%0d", c), 1'b1, 2'd3, 4'h8, 1'b1, 8'h44, 1'b0, 16'd1);
    end
    tick(1'b1, 4'h9, 4'h0, 1'b0, 32'h4433_2211);
    check_all("lr.in_reset", 1'b0, 2'd0, 4'h0, 1'b0, 8'h11, 1'b0, 16'd0);
    tick(1'b0, 4'h9, 4'h0, 1'b0, 32'h4433_2211);
    chk("lr.post_idle", 32'(busy), 32'd0);
    tick(1'b0, 4'h9, 4'h0, 1'b0, 32'h4433_2211);
    check_all("lr.regrant", 1'b1, 2'd0, 4'h1, 1'b1, 8'h11, 1'b0, 16'd0);

    // Randomized traffic against a cycle-level reference model.
    tick(1'b1, 4'h0, 4'h0, 1'b0, 32'h0);
    m_lock = 0; m_owner = 0; m_ptr = 0; m_idle = 0; m_pkts = 0;
    active = '1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic       r, f, e_abort, e_wen;
      logic [3:0] v, l, e_rdy;
      logic [31:0] d;
      int         sel;
      if (cyc % 32 == 0)
        for (int i = 0; i < 4; i++) active[i] = ($urandom % 4) != 0;
      r = ($urandom % 500) == 0;
      for (int i = 0; i < 4; i++) begin
        v[i] = active[i] && (($urandom % 10) < 8);
        l[i] = ($urandom % 10) < 3;
      end
      f = ($urandom % 5) == 0;
      d = $urandom;
      tick(r, v, l, f, d);

      if (r) begin
        m_lock = 0; m_owner = 0; m_ptr = 0; m_idle = 0; m_pkts = 0;
        check_all("rand_rst", 1'b0, 2'd0, 4'h0, 1'b0, d[7:0], 1'b0, 16'd0);
      end else begin
        sel     = (m_lock != 0) ? m_owner : 0;
        e_abort = (m_lock != 0) && (m_idle == int'(TO));
        e_wen   = (m_lock != 0) && !e_abort && v[m_owner] && !f;
        e_rdy   = ((m_lock != 0) && !e_abort && !f) ? 4'(1 << m_owner) : 4'h0;
        check_all("rand", 1'(m_lock), 2'(sel), e_rdy, e_wen, 8'(d >> (8 * sel)),
                  e_abort, 16'(m_pkts));
        if (m_lock == 0) begin
          for (int k = 0; k < 4; k++) begin
            if (m_lock == 0 && v[(m_ptr + k) % 4]) begin
              m_lock  = 1;
              m_owner = (m_ptr + k) % 4;
              m_idle  = 0;
            end
          end
        end else if (e_abort) begin
          m_lock = 0;
          m_ptr  = (m_owner + 1) % 4;
        end else if (e_wen && l[m_owner]) begin
          m_lock = 0;
          m_ptr  = (m_owner + 1) % 4;
          m_pkts = (m_pkts + 1) % 65536;
        end else begin
          m_idle = v[m_owner] ? 0 : m_idle + 1;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each data word.
REQ-002 Parameter NUM_REQ, default 4, number of requesters; legal range 2..16.
REQ-003 Parameter TIMEOUT, default 16, idle cycles allowed inside a packet before forced release; legal range 2..255.
REQ-004 Port clk  input  1  single clock; all logic is clocked on the rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port req_valid  input  NUM_REQ  per-requester beat valid.
REQ-007 Port req_last  input  NUM_REQ  per-requester last-beat-of-packet marker.
REQ-008 Port req_data  input  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port req_ready  output  NUM_REQ  per-requester beat accept.
REQ-010 Port fifo_full  input  1  FIFO write-side full flag.
REQ-011 Port fifo_w_en  output  1  FIFO write enable.
REQ-012 Port fifo_data  output  DATA_WIDTH  FIFO write data.
REQ-013 Port grant_id  output  $clog2(NUM_REQ)  index of the locked requester; 0 when idle.
REQ-014 Port busy  output  1  high while in LOCK.
REQ-015 Port timeout_err  output  1  one-cycle pulse on forced release.
REQ-016 Port pkt_count  output  16  count of completed packets; wraps 0xFFFF->0.

Function
REQ-017 The FSM SHALL have two states, IDLE and LOCK.
REQ-018 In IDLE with any req_valid high, the block SHALL select the first valid requester scanning upward from rr_ptr with wrap, latch it as grant_id, and enter LOCK on the next edge.
REQ-019 The arbitration latency SHALL be one cycle: no beat is accepted in IDLE, and req_ready SHALL be all-zero in IDLE.
REQ-020 In LOCK, req_ready[grant_id] SHALL equal !fifo_full combinationally; all other req_ready bits SHALL be 0.
REQ-021 fifo_w_en SHALL equal busy & req_valid[grant_id] & !fifo_full, combinationally.
REQ-022 fifo_data SHALL equal the req_data slice of grant_id, combinationally.
REQ-023 A beat SHALL transfer only when fifo_w_en is high, so no write is issued while fifo_full is high.
REQ-024 A transferring beat with req_last[grant_id] high SHALL cause a return to IDLE, set rr_ptr to (grant_id+1) mod NUM_REQ, and increment pkt_count, all at the same edge.
REQ-025 A last beat presented while fifo_full is high SHALL NOT transfer; the state stays LOCK until the beat transfers.
REQ-026 Packet lock: requests from other requesters SHALL be ignored in LOCK regardless of priority.
REQ-027 The stall counter (8-bit) SHALL increment in each LOCK cycle with req_valid[grant_id] low.
REQ-028 The stall counter SHALL clear on any cycle with req_valid[grant_id] high and on entry to LOCK.
REQ-029 Cycles stalled only by fifo_full SHALL NOT count toward TIMEOUT.
REQ-030 When the stall counter reaches TIMEOUT, the block SHALL:
- return to IDLE on the next edge;
- pulse timeout_err for exactly that one cycle;
- set rr_ptr to grant_id+1;
- leave pkt_count unchanged.
REQ-031 The requester that was aborted SHALL receive no further req_ready until it is re-granted through normal arbitration.
REQ-032 After a packet completes or aborts, the next grant SHALL take effect no earlier than one IDLE cycle later.

Reset
REQ-033 While rst is high, the block SHALL hold:
- state IDLE, rr_ptr 0, grant_id 0, stall counter 0, pkt_count 0;
- busy, timeout_err and fifo_w_en 0; req_ready all-zero.
REQ-034 Reset asserted mid-packet SHALL abandon the packet immediately, with no write issued in that cycle; the first grant after reset SHALL be the lowest-index valid requester.

Verification
REQ-035 Single packet: NUM_REQ=4, req1 sends 3 beats 0xA1,0xA2,0xA3 (last on 0xA3) -> grant_id=1 one cycle after valid, 3 fifo_w_en pulses with matching data, pkt_count=1, busy low afterward.
REQ-036 Round-robin: all 4 requesters continuously valid with 1-beat packets -> grant order 0,1,2,3,0, with one IDLE cycle between grants.
REQ-037 Full stall: req2 is locked with a 4-beat packet and fifo_full is held high for 5 cycles at beat 2 -> fifo_w_en 0 and req_ready[2] 0 during the stall, no timeout_err, all 4 beats written in order.
REQ-038 Timeout: TIMEOUT=16, req0 sends 1 beat without last, then drops valid -> timeout_err pulses 17 cycles after the last accepted beat, busy falls, pkt_count unchanged, the next grant goes to req1 if it is valid.
REQ-039 Lock and reset: with req3 locked and req0 valid, req0 is not granted; then rst pulses for 1 cycle mid-packet -> all outputs return to reset values, and the next grant is req0.
